aes_composite_dec: RTL and testbench

- Iterative AES-128 decryption core, one round per clock.
- Inverts the encryption datapath so the correlated-randomness flow can check and recover blocks produced by the encryptor.
- Accepts a cipher key once, derives the final round key internally, then decrypts 128-bit blocks on request.
- Inverse S-box is built in GF((2^4)^2) composite-field form, sharing the field arithmetic with the encryption core.

---
 rtl/aes_composite_dec.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_composite_dec.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_composite_dec.sv
// Iterative AES-128 decryption core, one round per clock. The key is expanded forward once to
// rk10, and each round then walks the schedule backwards. S-box inversion uses composite-field arithmetic.
module aes_composite_dec #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic         Krdy,
  output logic         Kvld,
  input  logic [127:0] Din,
  input  logic         Drdy,
  output logic [127:0] Dout,
  output logic         Dvld,
  output logic         BSY
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, state_n;
  logic [3:0]   cnt, cnt_n, rc_idx;
  logic [127:0] rk, rk_n, rk10, rk10_n, blk, blk_n, dout_n;
  logic         key_ok, key_ok_n, kvld_n, dvld_n, bsy_n;
  logic [7:0]   rc;
  logic [31:0]  sw_in, sw_out, w3_prev;
  logic [127:0] rk_fwd, rk_inv, rnd_sub, rnd_mix;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^8) as a quadratic extension of GF(2^4): the norm a^17 lies in the subfield, where
  // its inverse is n^14, and a^-1 = a^16 * (a^17)^-1. Zero maps to zero.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a4, a8, a16, n, n2, n4, n8;
    a2  = gmul(a, a);
    a4  = gmul(a2, a2);
    a8  = gmul(a4, a4);
    a16 = gmul(a8, a8);
    n   = gmul(a16, a);
    n2  = gmul(n, n);
    n4  = gmul(n2, n2);
    n8  = gmul(n4, n4);
    return gmul(a16, gmul(gmul(n2, n4), n8));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One SubWord instance serves both the forward expansion and the backward walk during decryption
  always_comb begin
    rc_idx  = (state == DEC) ? (4'd11 - cnt) : cnt;
    case (rc_idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    w3_prev = rk[31:0] ^ rk[63:32];
    sw_in   = (state == DEC) ? {w3_prev[23:0], w3_prev[31:24]} : {rk[23:0], rk[31:24]};
    sw_out  = {sbox(sw_in[31:24]) ^ rc, sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
    rk_fwd[127:96] = rk[127:96] ^ sw_out;
    rk_fwd[95:64]  = rk[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk[31:0] ^ rk_fwd[63:32];
    rk_inv  = {rk[127:96] ^ sw_out, rk[95:64] ^ rk[127:96], rk[63:32] ^ rk[95:64], w3_prev};
    rnd_sub = inv_shift_sub(blk) ^ rk_inv;
    rnd_mix = inv_mix_columns(rnd_sub);
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rk_n     = rk;
    rk10_n   = rk10;
    blk_n    = blk;
    key_ok_n = key_ok;
    dout_n   = Dout;
    kvld_n   = 1'b0;
    dvld_n   = 1'b0;
    bsy_n    = BSY;
    case (state)
      IDLE: begin
        bsy_n = 1'b0;
        if (Krdy) begin
          rk_n     = Kin;
          cnt_n    = 4'd1;
          bsy_n    = 1'b1;
          key_ok_n = 1'b0;
          state_n  = KEXP;
        end else if (Drdy && key_ok) begin
          blk_n   = Din ^ rk10;
          rk_n    = rk10;
          cnt_n   = 4'd1;
          bsy_n   = 1'b1;
          state_n = DEC;
        end
      end
      KEXP: begin
        if (cnt == 4'd0 || cnt > LAST) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          bsy_n   = 1'b0;
        end else begin
          rk_n = rk_fwd;
          if (cnt == LAST) begin
            rk10_n   = rk_fwd;
            key_ok_n = 1'b1;
            kvld_n   = 1'b1;
            bsy_n    = 1'b0;
            cnt_n    = 4'd0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      DEC: begin
        if (cnt == 4'd0 || cnt > LAST) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
          bsy_n   = 1'b0;
        end else if (cnt == LAST) begin
          dout_n = rnd_sub;
          dvld_n = 1'b1;
          rk_n   = rk10;
          // A request waiting at the last round starts the next block straight away
          if (Drdy) begin
            blk_n = Din ^ rk10;
            cnt_n = 4'd1;
          end else begin
            cnt_n   = 4'd0;
            bsy_n   = 1'b0;
            state_n = IDLE;
          end
        end else begin
          blk_n = rnd_mix;
          rk_n  = rk_inv;
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        bsy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      rk     <= '0;
      rk10   <= '0;
      blk    <= '0;
      key_ok <= 1'b0;
      Dout   <= '0;
      Kvld   <= 1'b0;
      Dvld   <= 1'b0;
      BSY    <= 1'b0;
    end else if (EN) begin
      state  <= state_n;
      cnt    <= cnt_n;
      rk     <= rk_n;
      rk10   <= rk10_n;
      blk    <= blk_n;
      key_ok <= key_ok_n;
      Dout   <= dout_n;
      Kvld   <= kvld_n;
      Dvld   <= dvld_n;
      BSY    <= bsy_n;
    end
  end

endmodule

// File: tb/tb_aes_composite_dec.sv
// Bench for aes_composite_dec: known-answer vectors plus random blocks whose ciphertexts come from
// a forward AES-128 model built from table-driven arithmetic.
module tb_aes_composite_dec;

  logic         CLK = 1'b0;
  logic         RST, EN, Krdy, Drdy, Kvld, Dvld, BSY;
  logic [127:0] Kin, Din, Dout;
  int           total = 0;
  int           bad = 0;
  logic [7:0]   sbox [256];

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;

  aes_composite_dec #(.NR(10)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .Kin(Kin), .Krdy(Krdy), .Kvld(Kvld),
    .Din(Din), .Drdy(Drdy), .Dout(Dout), .Dvld(Dvld), .BSY(BSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gm(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Straight FIPS-197 encryption over byte arrays: full expanded key, then ten rounds
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp[0] = sbox[w[4*i-3]] ^ rc;
        tmp[1] = sbox[w[4*i-2]];
        tmp[2] = sbox[w[4*i-1]];
        tmp[3] = sbox[w[4*i-4]];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_key(input logic [127:0] key);
    Kin = key;
    Krdy = 1'b1;
    tick();
    Krdy = 1'b0;
  endtask

  task automatic wait_kvld(output int n);
    n = 0;
    while (!Kvld && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic start_dec(input logic [127:0] blk);
    Din = blk;
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
  endtask

  task automatic wait_dvld(output int n, output int busy);
    busy = BSY ? 1 : 0;
    n = 0;
    while (!Dvld && n < 40) begin
      tick();
      n++;
      if (BSY) busy++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({Kvld, Dvld, BSY} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=000", {Kvld, Dvld, BSY});
    end
    total++;
    if (Dout !== 128'h0) begin
      bad++;
      $display("[TB] FAIL reset_dout got=%h want=0", Dout);
    end
  endtask

  task automatic test_no_key();
    int dv, bs;
    dv = 0;
    bs = 0;
    Din = CT1;
    Drdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Dvld) dv++;
      if (BSY) bs++;
    end
    Drdy = 1'b0;
    total++;
    if (dv !== 0 || bs !== 0) begin
      bad++;
      $display("[TB] FAIL no_key_drdy got dvld=%0d bsy=%0d want 0/0", dv, bs);
    end
  endtask

  task automatic test_key_setup();
    int n;
    start_key(K1);
    total++;
    if (BSY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL key_bsy got=%b want=1", BSY);
    end
    wait_kvld(n);
    total++;
    if (n !== 10) begin
      bad++;
      $display("[TB] FAIL key_latency got=%0d want=10", n);
    end
    total++;
    if (dut.rk10 !== K1_10) begin
      bad++;
      $display("[TB] FAIL key_rk10 got=%h want=%h", dut.rk10, K1_10);
    end
    tick();
    total++;
    if (Kvld !== 1'b0 || BSY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL key_pulse got kvld=%b bsy=%b want 0/0", Kvld, BSY);
    end
  endtask

  task automatic test_fips_vectors();
    int n, busy;
    logic [127:0] ks [2];
    logic [127:0] cs [2];
    logic [127:0] ps [2];
    start_dec(CT1);
    wait_dvld(n, busy);
    total++;
    if (n !== 10 || busy !== 10) begin
      bad++;
      $display("[TB] FAIL dec_timing got lat=%0d bsy=%0d want 10/10", n, busy);
    end
    total++;
    if (Dout !== PT1) begin
      bad++;
      $display("[TB] FAIL dec_k1 got=%h want=%h", Dout, PT1);
    end
    tick();
    tick();
    tick();
    total++;
    if (Dvld !== 1'b0 || Dout !== PT1) begin
      bad++;
      $display("[TB] FAIL dout_hold got dvld=%b dout=%h want 0/%h", Dvld, Dout, PT1);
    end
    ks[0] = 128'h000102030405060708090a0b0c0d0e0f;
    cs[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ps[0] = 128'h00112233445566778899aabbccddeeff;
    ks[1] = 128'h0;
    cs[1] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    ps[1] = 128'h0;
    for (int v = 0; v < 2; v++) begin
      start_key(ks[v]);
      wait_kvld(n);
      total++;
      if (n !== 10) begin
        bad++;
        $display("[TB] FAIL fips_key%0d latency got=%0d want=10", v, n);
      end
      tick();
      start_dec(cs[v]);
      wait_dvld(n, busy);
      total++;
      if (n !== 10 || Dout !== ps[v]) begin
        bad++;
        $display("[TB] FAIL fips_dec%0d got lat=%0d dout=%h want 10/%h", v, n, Dout, ps[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, hits;
    start_key(K1);
    wait_kvld(n);
    tick();
    hits = 0;
    Din = CT1;
    Drdy = 1'b1;
    tick();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (Dvld) begin
        hits++;
        total++;
        if (i !== 10 * hits) begin
          bad++;
          $display("[TB] FAIL b2b_spacing got cycle=%0d want=%0d", i, 10 * hits);
        end
        total++;
        if (Dout !== PT1) begin
          bad++;
          $display("[TB] FAIL b2b_dout got=%h want=%h", Dout, PT1);
        end
      end
    end
    Drdy = 1'b0;
    total++;
    if (hits !== 3) begin
      bad++;
      $display("[TB] FAIL b2b_count got=%0d want=3", hits);
    end
    n = 0;
    while (BSY && n < 30) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic test_enable_stall();
    int n;
    logic [127:0] pt, ct;
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = aes_enc(K1, pt);
    start_dec(ct);
    n = 0;
    while (!Dvld && n < 60) begin
      if (n == 4) EN = 1'b0;
      if (n == 9) EN = 1'b1;
      tick();
      n++;
    end
    EN = 1'b1;
    total++;
    if (n !== 15) begin
      bad++;
      $display("[TB] FAIL stall_latency got=%0d want=15", n);
    end
    total++;
    if (Dout !== pt) begin
      bad++;
      $display("[TB] FAIL stall_dout got=%h want=%h", Dout, pt);
    end
    tick();
  endtask

  task automatic test_priority();
    int n, dv;
    do_reset();
    Kin = K1;
    Din = CT1;
    Krdy = 1'b1;
    Drdy = 1'b1;
    tick();
    Krdy = 1'b0;
    n = 0;
    dv = 0;
    while (!Kvld && n < 40) begin
      tick();
      n++;
      if (Dvld) dv++;
    end
    Drdy = 1'b0;
    total++;
    if (n !== 10 || dv !== 0) begin
      bad++;
      $display("[TB] FAIL key_priority got lat=%0d dvld=%0d want 10/0", n, dv);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int n, busy, dv;
    logic [127:0] key, pt, ct;
    start_dec(CT1);
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if ({Kvld, Dvld, BSY} !== 3'b000 || Dout !== 128'h0) begin
      bad++;
      $display("[TB] FAIL abort_reset got flags=%b dout=%h want 000/0", {Kvld, Dvld, BSY}, Dout);
    end
    dv = 0;
    Din = CT1;
    Drdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Dvld || BSY) dv++;
    end
    Drdy = 1'b0;
    total++;
    if (dv !== 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet got=%0d want=0", dv);
    end
    key = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = aes_enc(key, pt);
    start_key(key);
    wait_kvld(n);
    tick();
    start_dec(ct);
    wait_dvld(n, busy);
    total++;
    if (n !== 10 || Dout !== pt) begin
      bad++;
      $display("[TB] FAIL abort_recover got lat=%0d dout=%h want 10/%h", n, Dout, pt);
    end
    tick();
  endtask

  task automatic test_random();
    int n, busy;
    logic [127:0] key, pt, ct;
    for (int k = 0; k < 5; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      start_key(key);
      wait_kvld(n);
      total++;
      if (n !== 10) begin
        bad++;
        $display("[TB] FAIL rand_key%0d latency got=%0d want=10", k, n);
      end
      tick();
      for (int b = 0; b < 2; b++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = aes_enc(key, pt);
        start_dec(ct);
        wait_dvld(n, busy);
        total++;
        if (n !== 10 || Dout !== pt) begin
          bad++;
          $display("[TB] FAIL rand_dec%0d_%0d got lat=%0d dout=%h want 10/%h", k, b, n, Dout, pt);
        end
        tick();
      end
    end
  endtask

  initial begin
    RST  = 1'b1;
    EN   = 1'b1;
    Krdy = 1'b0;
    Drdy = 1'b0;
    Kin  = '0;
    Din  = '0;
    build_sbox();
    test_reset();
    test_no_key();
    test_key_setup();
    test_fips_vectors();
    test_back_to_back();
    test_enable_stall();
    test_priority();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
